// File: rtl/alu_iter_pkg.sv
// Shared constants for the multi-cycle core: ALU control codes (also used by the
// decoder), ALU FSM state encoding, and a shift-op classifier.
package alu_iter_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SRA = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } aluctrl_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_shift1.sv
// Single-bit shifter: left inserts zero at bit 0; right inserts zero or the
// sign bit at bit 31 depending on arith.
module alu_shift1 (
  input  logic [31:0] din,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] dout
);

  assign dout = left ? {din[30:0], 1'b0} : {arith & din[31], din[31:1]};

endmodule

// File: rtl/alu_iter.sv
// Iterative 32-bit ALU: one-cycle ADD/SUB/logic ops, serial one-bit-per-cycle
// shifts. Optional registered flags when ALU_FLAGS_EN is defined.
module alu_iter
  import alu_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  aluctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        flag_v
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready is high,
  // on both the input side (in_valid/in_ready) and output side (out_valid/out_ready).
  state_e      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [31:0] work, work_d, shifted, op_res, b_eff, sum;
  logic        shl, sha, shl_d, sha_d, ov_d;
  logic        accept, start_shift, imm_done, shift_done, is_sub;

  assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift(aluctrl) && (b[4:0] != 5'd0);
  assign imm_done    = accept && !start_shift;
  assign shift_done  = (state == ST_SHIFT) && (cnt == 5'd1);

  assign is_sub = (aluctrl == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
  logic [32:0] sum33;
  logic        carry, ovf, is_arith;
  assign sum33    = {1'b0, a} + {1'b0, b_eff} + 33'(is_sub);
  assign sum      = sum33[31:0];
  assign carry    = sum33[32];
  assign ovf      = (a[31] == b_eff[31]) && (sum[31] != a[31]);
  assign is_arith = (aluctrl == ALU_ADD) || (aluctrl == ALU_SUB);
`else
  assign sum = a + b_eff + 32'(is_sub);
`endif

  alu_shift1 u_shift1 (
    .din   (work),
    .left  (shl),
    .arith (sha),
    .dout  (shifted)
  );

  // Shift codes reaching this mux have a zero shift amount, so they pass a through.
  always_comb begin
    op_res = a;
    case (aluctrl_e'(aluctrl))
      ALU_ADD, ALU_SUB: op_res = sum;
      ALU_XOR:          op_res = a ^ b;
      ALU_OR:           op_res = a | b;
      ALU_AND:          op_res = a & b;
      default:          op_res = a;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    work_d  = work;
    shl_d   = shl;
    sha_d   = sha;
    ov_d    = out_valid && !out_ready;
    case (state)
      ST_IDLE: begin
        if (start_shift) begin
          work_d  = a;
          cnt_d   = b[4:0];
          shl_d   = (aluctrl == ALU_SLL);
          sha_d   = (aluctrl == ALU_SRA);
          ov_d    = 1'b0;
          state_d = ST_SHIFT;
        end else if (imm_done) begin
          work_d = op_res;
          ov_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt - 5'd1;
        if (shift_done) begin
          ov_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      work      <= 32'd0;
      shl       <= 1'b0;
      sha       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      work      <= work_d;
      shl       <= shl_d;
      sha       <= sha_d;
      out_valid <= ov_d;
    end
  end

  assign result = work;

`ifdef ALU_FLAGS_EN
  // Flags load alongside the working register whenever a result becomes valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (imm_done) begin
      flag_z <= (op_res == 32'd0);
      flag_n <= op_res[31];
      flag_c <= is_arith && carry;
      flag_v <= is_arith && ovf;
    end else if (shift_done) begin
      flag_z <= (shifted == 32'd0);
      flag_n <= shifted[31];
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/alu_iter.md
# alu_iter

Iterative 32-bit ALU executing the 3-bit ALU control codes produced by the instruction decoder for the multi-cycle core. It accepts an operation through a valid/ready handshake and computes ADD/SUB/XOR/OR/AND in one cycle. Shifts run serially, one bit per cycle, to avoid a barrel shifter. The result sits in an output register until the downstream writeback or branch stage takes it.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation this cycle.
- `aluctrl`  in  3  ALU control code.
- `a`  in  32  operand A (rs1 or PC).
- `b`  in  32  operand B (rs2 or immediate). Shifts use `b[4:0]` as shift amount.
- `out_valid`  out  1  `result` and flags are valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  32  operation result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative, carry, overflow (only with `ALU_FLAGS_EN`).

## Operation
- Control codes: ADD=000, SUB=001, SLL=010, XOR=011, SRL=100, SRA=101, OR=110, AND=111. All 8 codes are legal.
- States: IDLE and SHIFT.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). An input is accepted when `in_valid && in_ready`.
- Accept of a non-shift op, or of a shift with `b[4:0]`==0:
  - `result` is loaded with the op's result (shift by 0 loads `a`).
  - `out_valid` goes to 1.
  - State stays IDLE.
- Accept of a shift with shamt>0:
  - Working register = `a`, counter = shamt, state → SHIFT, `out_valid` → 0.
  - Each SHIFT cycle shifts by one bit (SLL: zero in at bit 0; SRL: zero in at bit 31; SRA: bit 31 replicated) and decrements the counter.
  - The cycle in which the counter goes from 1 to 0 completes the shift: `out_valid` → 1, state → IDLE.
- `result` is the working register itself; it is stable while `out_valid`=1.
- `out_valid` clears on `out_valid && out_ready` unless a new non-shift op is accepted the same cycle; in that case `out_valid` stays 1 with the new result.
- Operands are captured at accept. Changes on `a`, `b`, `aluctrl` after accept have no effect.
- `in_valid` is ignored while `in_ready`=0. The upstream holds its operation until accepted.
- Arithmetic is modulo 2^32; SUB = a + ~b + 1.

## Timing
- Reset (async assert, sync-released by the system): state IDLE, `out_valid`=0, `result`=0, counter=0, all flags 0. `in_ready`=1 during the first cycle after reset.
- Latency, accept edge → `out_valid` high:
  - 1 cycle for non-shift ops and shamt=0.
  - 1+shamt cycles for shifts: shamt 31 → 32 cycles.
- Throughput is one non-shift op per cycle when `out_ready` is held high.
- Reset asserted mid-shift aborts the operation immediately; no partial result is presented.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Configuration
- `ALU_FLAGS_EN` defined: flags are registered with `result`.
  - `flag_z` = (result==0).
  - `flag_n` = result[31].
  - `flag_c` = carry-out for ADD; for SUB it is 1 when no borrow (a ≥ b unsigned). SLTU and BLTU use !flag_c.
  - `flag_v` = signed overflow for ADD/SUB. SLT and BLT use flag_n ^ flag_v.
  - For logic and shift ops, `flag_c`=`flag_v`=0 and `flag_z`/`flag_n` follow `result`.
- Not defined: the four flag ports are absent and no flag logic is synthesized. Branch compare is then done elsewhere.

## Structure
- The control-code constants go in the shared macro header alongside the decoder's definitions, so decoder and ALU use the same constants.
- Add state encoding IDLE=0 and SHIFT=1 to the shared header.
- One sub-module, `alu_shift1`: combinational single-bit shift by direction and arithmetic select, instantiated on the working register.

## Test plan
- ADD a=0x7FFFFFFF, b=1, `out_ready`=1 → one cycle later `result`=0x80000000. With flags: n=1, v=1, c=0, z=0.
- SUB a=5, b=5 → `result`=0, z=1, c=1. SUB a=3, b=5 → `result`=0xFFFFFFFE, c=0, n=1.
- SRA a=0x80000000, b=31 → `in_ready`=0 for 31 cycles; `out_valid` 32 cycles after accept; `result`=0xFFFFFFFF. SRL with the same operands → 0x00000001.
- SLL a=0x1, b=0 → `result`=0x1 after 1 cycle; SLL a=0x1, b=4 → 0x10 after 5 cycles.
- Back-to-back XOR, OR, AND with `out_ready` held 0 → first result held and `in_ready`=0. Raise `out_ready` → results drained in order, one per cycle.
- `rst_n` pulled low at shift cycle 3 of shamt 20 → `out_valid`=0 and `in_ready`=1 after release; the next ADD 2+2 returns 4.
